// File: rtl/multi_user_auth_gen_pkg.sv
// Shared definitions for the multi-user login front end: FSM states, width
// helpers and the factory-default user table (hex digits, entry 0 = guest).
package multi_user_auth_gen_pkg;

  typedef enum logic [2:0] {
    GET_ID,
    CHECK_ID,
    GET_PW,
    CHECK_PW,
    ACTIVE,
    LOCKED
  } authStateT;

  localparam int TABLE_DEPTH = 16;

  localparam logic [0:TABLE_DEPTH-1][15:0] DEFAULT_IDS = {
    16'h0000, 16'h1111, 16'h2468, 16'h3141, 16'h4040, 16'h1234, 16'h5555, 16'h8080,
    16'h9999, 16'h1010, 16'h6543, 16'h7070, 16'h8421, 16'h3333, 16'h9012, 16'h6060
  };

  localparam logic [0:TABLE_DEPTH-1][15:0] DEFAULT_PWS = {
    16'h0000, 16'h4321, 16'h1357, 16'h5926, 16'h0404, 16'h9876, 16'h6666, 16'h1212,
    16'h0001, 16'h2020, 16'h3456, 16'h0707, 16'h1248, 16'h4444, 16'h2109, 16'h0606
  };

  function automatic int idxWidth(input int numUsers);
    return (numUsers > 1) ? $clog2(numUsers) : 1;
  endfunction

  function automatic int cntWidth(input int maxValue);
    return (maxValue > 0) ? $clog2(maxValue + 1) : 1;
  endfunction

  // Digit pos counts from the most significant digit of a stored entry.
  function automatic logic [3:0] tableDigit(input logic [15:0] entry, input int pos);
    case (pos)
      0:       return entry[15:12];
      1:       return entry[11:8];
      2:       return entry[7:4];
      3:       return entry[3:0];
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/multi_user_auth_gen_user_table.sv
// Combinational user table: index in, {id, pw} out. Backed by package
// constants today so it can be replaced by a RAM without touching the FSM.
module auth_user_table
  import multi_user_auth_gen_pkg::*;
#(
  parameter int NUM_USERS = 16,
  parameter int DIGIT_W   = 4,
  parameter int ID_DIGITS = 4,
  parameter int PW_DIGITS = 4,
  localparam int IDX_W    = idxWidth(NUM_USERS)
) (
  input  logic [IDX_W-1:0]              index,
  output logic [ID_DIGITS*DIGIT_W-1:0]  userId,
  output logic [PW_DIGITS*DIGIT_W-1:0]  userPw
);

  logic [15:0] idEntry;
  logic [15:0] pwEntry;

  // Entries beyond the default table read as all-zero digits and can never
  // win the search, because the guest at index 0 is always checked first.
  always_comb begin
    idEntry = 16'h0000;
    pwEntry = 16'h0000;
    if (int'(index) < TABLE_DEPTH) begin
      idEntry = DEFAULT_IDS[4'(index)];
      pwEntry = DEFAULT_PWS[4'(index)];
    end
  end

  always_comb begin
    userId = '0;
    for (int d = 0; d < ID_DIGITS; d++) begin
      userId[(ID_DIGITS-1-d)*DIGIT_W +: DIGIT_W] = DIGIT_W'(tableDigit(idEntry, d));
    end
  end

  always_comb begin
    userPw = '0;
    for (int d = 0; d < PW_DIGITS; d++) begin
      userPw[(PW_DIGITS-1-d)*DIGIT_W +: DIGIT_W] = DIGIT_W'(tableDigit(pwEntry, d));
    end
  end

endmodule

// File: rtl/multi_user_auth_gen.sv
// Login front end: collects ID/password digits, searches the user table,
// and manages sessions with failed-attempt lockout and idle timeout.
module multi_user_auth_gen
  import multi_user_auth_gen_pkg::*;
#(
  parameter int NUM_USERS      = 16,
  parameter int DIGIT_W        = 4,
  parameter int ID_DIGITS      = 4,
  parameter int PW_DIGITS      = 4,
  parameter int MAX_FAIL       = 3,
  parameter int LOCK_CYCLES    = 1000,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int IDX_W         = idxWidth(NUM_USERS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Game_Enter,
  input  logic [DIGIT_W-1:0] User_digit,
  input  logic               GCLogOut,
  output logic               LogIn,
  output logic               LogOut,
  output logic [IDX_W-1:0]   InternalID,
  output logic               Busy,
  output logic               Locked
);

  localparam int ID_W   = ID_DIGITS * DIGIT_W;
  localparam int PW_W   = PW_DIGITS * DIGIT_W;
  localparam int DCNT_W = cntWidth((ID_DIGITS > PW_DIGITS) ? ID_DIGITS : PW_DIGITS);
  localparam int FAIL_W = cntWidth(MAX_FAIL);
  localparam int LOCK_W = cntWidth(LOCK_CYCLES);
  localparam int IDLE_W = cntWidth(TIMEOUT_CYCLES);

  localparam logic [DCNT_W-1:0] ID_LAST    = DCNT_W'(ID_DIGITS - 1);
  localparam logic [DCNT_W-1:0] PW_LAST    = DCNT_W'(PW_DIGITS - 1);
  localparam logic [IDX_W-1:0]  SEARCH_END = IDX_W'(NUM_USERS - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST  = FAIL_W'(MAX_FAIL - 1);
  localparam logic [LOCK_W-1:0] LOCK_LAST  = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  authStateT state;
  authStateT nextState;

  logic [ID_W-1:0]   idReg;
  logic [PW_W-1:0]   pwReg;
  logic [DCNT_W-1:0] digitCnt;
  logic [IDX_W-1:0]  searchIdx;
  logic [IDX_W-1:0]  userIdx;
  logic [FAIL_W-1:0] failCnt;
  logic [LOCK_W-1:0] lockTimer;
  logic [IDLE_W-1:0] idleTimer;

  logic [IDX_W-1:0]  tableIndex;
  logic [ID_W-1:0]   tableId;
  logic [PW_W-1:0]   tablePw;

  logic idMatch;
  logic pwMatch;
  logic lastSearch;
  logic entryDone;
  logic sessionEnd;
  logic failEvent;
  logic lockNow;
  logic logInNext;
  logic logOutNext;
  logic [IDX_W-1:0] internalIdNext;

  assign tableIndex = (state == CHECK_PW) ? userIdx : searchIdx;

  auth_user_table #(
    .NUM_USERS (NUM_USERS),
    .DIGIT_W   (DIGIT_W),
    .ID_DIGITS (ID_DIGITS),
    .PW_DIGITS (PW_DIGITS)
  ) userTable (
    .index  (tableIndex),
    .userId (tableId),
    .userPw (tablePw)
  );

  // Shared decode for the FSM and datapath; a failure whose count hits
  // MAX_FAIL sends the FSM to LOCKED instead of back to ID entry.
  always_comb begin
    idMatch    = tableId == idReg;
    pwMatch    = tablePw == pwReg;
    lastSearch = searchIdx == SEARCH_END;
    entryDone  = Game_Enter && (((state == GET_ID) && (digitCnt == ID_LAST)) ||
                                ((state == GET_PW) && (digitCnt == PW_LAST)));
    sessionEnd = GCLogOut || ((TIMEOUT_CYCLES != 0) && (idleTimer == IDLE_LAST));
    failEvent  = ((state == CHECK_ID) && !idMatch && lastSearch) ||
                 ((state == CHECK_PW) && !pwMatch);
    lockNow    = failEvent && (failCnt == FAIL_LAST);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= GET_ID;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      GET_ID:   if (entryDone) nextState = CHECK_ID;
      CHECK_ID: begin
        if (idMatch) begin
          nextState = (searchIdx == '0) ? ACTIVE : GET_PW;
        end else if (lastSearch) begin
          nextState = lockNow ? LOCKED : GET_ID;
        end
      end
      GET_PW:   if (entryDone) nextState = CHECK_PW;
      CHECK_PW: begin
        if (pwMatch) nextState = ACTIVE;
        else         nextState = lockNow ? LOCKED : GET_ID;
      end
      ACTIVE:   if (sessionEnd) nextState = GET_ID;
      LOCKED:   if (lockTimer == LOCK_LAST) nextState = GET_ID;
      default:  nextState = GET_ID;
    endcase
  end

  // Session outputs are computed from the upcoming state so the registered
  // copies line up exactly with the ACTIVE window.
  always_comb begin
    Busy           = (state == CHECK_ID) || (state == CHECK_PW);
    Locked         = state == LOCKED;
    logInNext      = nextState == ACTIVE;
    logOutNext     = (state == ACTIVE) && (nextState != ACTIVE);
    internalIdNext = '0;
    if (nextState == ACTIVE) begin
      internalIdNext = (state == CHECK_PW) ? userIdx : InternalID;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      LogIn      <= 1'b0;
      LogOut     <= 1'b0;
      InternalID <= '0;
    end else begin
      LogIn      <= logInNext;
      LogOut     <= logOutNext;
      InternalID <= internalIdNext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idReg     <= '0;
      pwReg     <= '0;
      digitCnt  <= '0;
      searchIdx <= '0;
      userIdx   <= '0;
      failCnt   <= '0;
      lockTimer <= '0;
      idleTimer <= '0;
    end else begin
      if ((state == GET_ID) && Game_Enter) begin
        idReg <= (idReg << DIGIT_W) | ID_W'(User_digit);
      end
      if ((state == GET_PW) && Game_Enter) begin
        pwReg <= (pwReg << DIGIT_W) | PW_W'(User_digit);
      end

      if ((state == GET_ID) || (state == GET_PW)) begin
        if (Game_Enter) digitCnt <= entryDone ? '0 : digitCnt + DCNT_W'(1);
      end else begin
        digitCnt <= '0;
      end

      if ((state == CHECK_ID) && !idMatch && !lastSearch) begin
        searchIdx <= searchIdx + IDX_W'(1);
      end else begin
        searchIdx <= '0;
      end

      if ((state == CHECK_ID) && idMatch) userIdx <= searchIdx;

      if (failEvent) begin
        failCnt <= lockNow ? '0 : failCnt + FAIL_W'(1);
      end else if ((state == CHECK_PW) && pwMatch) begin
        failCnt <= '0;
      end

      if ((state == LOCKED) && (lockTimer != LOCK_LAST)) begin
        lockTimer <= lockTimer + LOCK_W'(1);
      end else begin
        lockTimer <= '0;
      end

      if (state != ACTIVE || Game_Enter) begin
        idleTimer <= '0;
      end else if (idleTimer != '1) begin
        idleTimer <= idleTimer + IDLE_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_multi_user_auth_gen.sv
// Self-checking bench: directed scenarios then randomized login attempts,
// checked against a transaction-level model of the login rules.
module tb_multi_user_auth_gen;

  localparam int NUM_USERS = 16;
  localparam int MAX_FAIL  = 3;
  localparam int LOCK      = 20;
  localparam int TIMEOUT   = 16;

  logic       clk;
  logic       rst;
  logic       Game_Enter;
  logic [3:0] User_digit;
  logic       GCLogOut;
  logic       LogIn;
  logic       LogOut;
  logic [3:0] InternalID;
  logic       Busy;
  logic       Locked;

  int testsRun    = 0;
  int testsFailed = 0;
  int expFail     = 0;

  int tblId [NUM_USERS] = '{'h0000, 'h1111, 'h2468, 'h3141, 'h4040, 'h1234, 'h5555, 'h8080,
                            'h9999, 'h1010, 'h6543, 'h7070, 'h8421, 'h3333, 'h9012, 'h6060};
  int tblPw [NUM_USERS] = '{'h0000, 'h4321, 'h1357, 'h5926, 'h0404, 'h9876, 'h6666, 'h1212,
                            'h0001, 'h2020, 'h3456, 'h0707, 'h1248, 'h4444, 'h2109, 'h0606};

  multi_user_auth_gen #(
    .NUM_USERS      (NUM_USERS),
    .DIGIT_W        (4),
    .ID_DIGITS      (4),
    .PW_DIGITS      (4),
    .MAX_FAIL       (MAX_FAIL),
    .LOCK_CYCLES    (LOCK),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Game_Enter (Game_Enter),
    .User_digit (User_digit),
    .GCLogOut   (GCLogOut),
    .LogIn      (LogIn),
    .LogOut     (LogOut),
    .InternalID (InternalID),
    .Busy       (Busy),
    .Locked     (Locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic int lookupId(input int value);
    for (int i = 0; i < NUM_USERS; i++) begin
      if (tblId[i] == value) return i;
    end
    return -1;
  endfunction

  // Sends four hex digits MSD first, optionally with idle gaps carrying
  // junk digits and stray GCLogOut levels that must have no effect.
  task automatic applyStimulus(input int value, input bit gaps);
    for (int i = 3; i >= 0; i--) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          Game_Enter = 1'b0;
          User_digit = 4'($urandom);
          GCLogOut   = 1'($urandom_range(0, 1));
          tick();
        end
      end
      GCLogOut   = 1'b0;
      Game_Enter = 1'b1;
      User_digit = 4'((value >> (4 * i)) & 15);
      tick();
    end
    Game_Enter = 1'b0;
    GCLogOut   = 1'b0;
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (Busy === 1'b1 && n < 64) begin
      n++;
      tick();
    end
  endtask

  task automatic countLocked(output int n);
    n = 0;
    while (Locked === 1'b1 && n < 64) begin
      Game_Enter = 1'($urandom_range(0, 1));
      User_digit = 4'($urandom);
      n++;
      tick();
    end
    Game_Enter = 1'b0;
  endtask

  task automatic endSession();
    GCLogOut = 1'b1;
    tick();
    GCLogOut = 1'b0;
    checkOutput("logoutPulse", LogOut, 1);
    checkOutput("logoutLogIn", LogIn, 0);
    checkOutput("logoutId", InternalID, 0);
    tick();
    checkOutput("logoutOneCycle", LogOut, 0);
    checkOutput("logoutStaysOut", LogIn, 0);
  endtask

  task automatic registerFailure();
    int n;
    expFail++;
    checkOutput("failLogIn", LogIn, 0);
    checkOutput("failLogOut", LogOut, 0);
    if (expFail == MAX_FAIL) begin
      expFail = 0;
      checkOutput("lockEntered", Locked, 1);
      countLocked(n);
      checkOutput("lockCycles", n, LOCK);
    end else begin
      checkOutput("noLock", Locked, 0);
    end
  endtask

  task automatic runAttempt(input int idVal, input int pwVal, input bit gaps);
    int k;
    int n;
    applyStimulus(idVal, gaps);
    k = lookupId(idVal);
    countBusy(n);
    checkOutput("idSearchCycles", n, (k >= 0) ? k + 1 : NUM_USERS);
    if (k == 0) begin
      checkOutput("guestLogIn", LogIn, 1);
      checkOutput("guestId", InternalID, 0);
      checkOutput("guestLogOut", LogOut, 0);
      endSession();
    end else if (k < 0) begin
      registerFailure();
    end else begin
      checkOutput("awaitPwLogIn", LogIn, 0);
      applyStimulus(pwVal, gaps);
      countBusy(n);
      checkOutput("pwCheckCycles", n, 1);
      if (pwVal == tblPw[k]) begin
        expFail = 0;
        checkOutput("userLogIn", LogIn, 1);
        checkOutput("userId", InternalID, k);
        endSession();
      end else begin
        registerFailure();
      end
    end
  endtask

  task automatic waitTimeout(input int strobeAt, input int expected);
    int n;
    applyStimulus('h1234, 1'b0);
    countBusy(n);
    applyStimulus('h9876, 1'b0);
    countBusy(n);
    expFail = 0;
    checkOutput("timeoutLogin", LogIn, 1);
    n = 0;
    while (LogOut !== 1'b1 && n < 64) begin
      Game_Enter = (n == strobeAt);
      User_digit = 4'($urandom);
      tick();
      n++;
    end
    Game_Enter = 1'b0;
    checkOutput("timeoutCycles", n, expected);
    checkOutput("timeoutLogIn", LogIn, 0);
    checkOutput("timeoutId", InternalID, 0);
    tick();
    checkOutput("timeoutPulseWidth", LogOut, 0);
  endtask

  task automatic checkAllLow(input string tag);
    checkOutput({tag, "LogIn"}, LogIn, 0);
    checkOutput({tag, "LogOut"}, LogOut, 0);
    checkOutput({tag, "Id"}, InternalID, 0);
    checkOutput({tag, "Busy"}, Busy, 0);
    checkOutput({tag, "Locked"}, Locked, 0);
  endtask

  initial begin
    int n;
    int kind;
    int k;
    int idVal;
    int pwVal;

    rst        = 1'b0;
    Game_Enter = 1'b0;
    User_digit = 4'h0;
    GCLogOut   = 1'b0;
    #12;
    checkAllLow("reset");
    @(negedge clk);
    rst = 1'b1;
    tick();

    runAttempt('h0000, 0, 1'b0);
    runAttempt('h7777, 0, 1'b0);
    runAttempt('h1234, 'h9876, 1'b0);

    runAttempt('h1234, 'h1111, 1'b0);
    runAttempt('h1234, 'h9875, 1'b0);
    runAttempt('h1234, 'h0000, 1'b0);
    runAttempt('h1234, 'h9876, 1'b0);

    waitTimeout(-1, TIMEOUT);
    waitTimeout(9, TIMEOUT + 10);

    applyStimulus('h7777, 1'b0);
    tick();
    tick();
    checkOutput("midSearchBusy", Busy, 1);
    #2 rst = 1'b0;
    #1 checkAllLow("rstSearch");
    expFail = 0;
    @(negedge clk);
    rst = 1'b1;
    tick();

    applyStimulus('h0000, 1'b0);
    countBusy(n);
    checkOutput("preRstLogIn", LogIn, 1);
    tick();
    #2 rst = 1'b0;
    #1 checkAllLow("rstActive");
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      tick();
      checkOutput("noRstLogOut", LogOut, 0);
    end
    runAttempt('h1234, 'h9876, 1'b0);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 3);
      k    = $urandom_range(1, NUM_USERS - 1);
      case (kind)
        0: runAttempt('h0000, 0, 1'b1);
        1: runAttempt(tblId[k], tblPw[k], 1'b1);
        2: begin
          do pwVal = $urandom_range(0, 'hFFFF); while (pwVal == tblPw[k]);
          runAttempt(tblId[k], pwVal, 1'b1);
        end
        default: begin
          do idVal = $urandom_range(0, 'hFFFF); while (lookupId(idVal) >= 0);
          runAttempt(idVal, 0, 1'b1);
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
